sentinel_auth_ctrl: RTL and testbench

- Sequencing controller for the Sentinel perimeter gate.
- Captures the DIP-switch key on a submit strobe and runs a fixed-latency, bit-serial compare against the hardcoded key, so the compare takes the same time whatever the mismatch position.
- Holds a timed UNLOCKED window, counts failed attempts, and enforces a lockout after repeated failures.
- Drives the 7-segment code and status flags consumed by the top-level tile wrapper.

---
 rtl/sentinel_pkg.sv | 31 +++
 rtl/sentinel_decoy.sv | 36 +++
 rtl/sentinel_sync_edge.sv | 27 ++
 rtl/sentinel_auth_ctrl.sv | 130 +++++++++++++
 tb/tb_sentinel_auth_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sentinel_pkg.sv
// Shared types and constants for the Sentinel gate controller.
package sentinel_pkg;

  typedef enum logic [1:0] {
    LOCKED,
    VERIFY,
    UNLOCKED,
    LOCKOUT
  } state_t;

  localparam logic [7:0] SEG_LOCKED   = 8'hC7;
  localparam logic [7:0] SEG_UNLOCKED = 8'hC1;
  localparam logic [7:0] SEG_LOCKOUT  = 8'hBF;
  localparam logic [7:0] SEG_OFF      = 8'hFF;

  localparam int unsigned VERIFY_BITS = 8;
  localparam logic [2:0]  LAST_BIT    = 3'(VERIFY_BITS - 1);
  localparam logic [7:0]  DECOY_KEY   = 8'h00;

  // VERIFY shows the same glyph as LOCKED so the compare window is not observable.
  function automatic logic [7:0] seg_decode(input state_t s);
    logic [7:0] seg;
    case (s)
      UNLOCKED: seg = SEG_UNLOCKED;
      LOCKOUT:  seg = SEG_LOCKOUT;
      default:  seg = SEG_LOCKED;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sentinel_decoy.sv
// Decoy bit-serial compare against DECOY_KEY, run in lockstep with the real VERIFY.
// Only built when SENTINEL_DECOY_EN is defined.
module sentinel_decoy
  import sentinel_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       step,
  input  logic [7:0] key_in,
  output logic       match
);

  logic [7:0] sr_q;
  logic [2:0] cnt_q;
  logic       match_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
    end else if (load) begin
      sr_q    <= key_in;
      cnt_q   <= '0;
      match_q <= 1'b1;
    end else if (step) begin
      sr_q    <= {sr_q[6:0], 1'b0};
      cnt_q   <= cnt_q + 3'd1;
      match_q <= match_q & (sr_q[7] == DECOY_KEY[LAST_BIT - cnt_q]);
    end
  end

  assign match = match_q;

endmodule

// File: rtl/sentinel_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector; emits a one-cycle pulse.
module sentinel_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign pulse = sync_q & ~prev_q;

endmodule

// File: rtl/sentinel_auth_ctrl.sv
// Sentinel gate sequencing controller: constant-time key compare, unlock window, lockout.
// Optional decoy compare enabled with SENTINEL_DECOY_EN.
module sentinel_auth_ctrl
  import sentinel_pkg::*;
#(
  parameter logic [7:0]  KEY            = 8'hB6,
  parameter logic [15:0] UNLOCK_CYCLES  = 16'd1000,
  parameter int unsigned MAX_FAILS      = 3,
  parameter logic [15:0] LOCKOUT_CYCLES = 16'd5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] key_in,
  input  logic       submit,
  output logic [7:0] seg_out,
  output logic       unlocked,
  output logic       lockout,
  output logic       busy,
  output logic [3:0] fail_count,
  output logic       decoy_out
);

  localparam logic [3:0] MaxFailsW = 4'(MAX_FAILS);

  logic       sub_p;
  logic       start;
  state_t     state_q;
  logic [7:0] sr_q;
  logic       match_q;
  logic [2:0] cnt_q;
  logic [15:0] timer_q;
  logic [3:0] fail_q;
  logic       match_d;

  sentinel_sync_edge u_submit_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (submit),
    .pulse (sub_p)
  );

  assign start = (state_q == LOCKED) && sub_p && ena;

  always_comb begin
    match_d = match_q & (sr_q[7] == KEY[LAST_BIT - cnt_q]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOCKED;
      sr_q    <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
      timer_q <= '0;
      fail_q  <= '0;
    end else begin
      case (state_q)
        LOCKED: begin
          if (start) begin
            sr_q    <= key_in;
            match_q <= 1'b1;  // cleared to "no mismatch seen yet"
            cnt_q   <= '0;
            state_q <= VERIFY;
          end
        end
        VERIFY: begin
          if (!ena) begin
            state_q <= LOCKED;
          end else begin
            sr_q    <= {sr_q[6:0], 1'b0};
            cnt_q   <= cnt_q + 3'd1;
            match_q <= match_d;
            // Decision only after all bits, regardless of where a mismatch occurred.
            if (cnt_q == LAST_BIT) begin
              if (match_d) begin
                fail_q  <= '0;
                timer_q <= UNLOCK_CYCLES - 16'd1;
                state_q <= UNLOCKED;
              end else if (fail_q + 4'd1 == MaxFailsW) begin
                fail_q  <= MaxFailsW;
                timer_q <= LOCKOUT_CYCLES - 16'd1;
                state_q <= LOCKOUT;
              end else begin
                fail_q  <= fail_q + 4'd1;
                state_q <= LOCKED;
              end
            end
          end
        end
        UNLOCKED: begin
          if (!ena || sub_p || timer_q == '0) begin
            state_q <= LOCKED;
          end else begin
            timer_q <= timer_q - 16'd1;
          end
        end
        LOCKOUT: begin
          if (timer_q == '0) begin
            fail_q  <= '0;
            state_q <= LOCKED;
          end else begin
            timer_q <= timer_q - 16'd1;
          end
        end
        default: state_q <= LOCKED;
      endcase
    end
  end

  assign seg_out    = ena ? seg_decode(state_q) : SEG_OFF;
  assign unlocked   = ena && (state_q == UNLOCKED);
  assign busy       = ena && (state_q == VERIFY);
  assign lockout    = (state_q == LOCKOUT);
  assign fail_count = fail_q;

`ifdef SENTINEL_DECOY_EN
  sentinel_decoy u_decoy (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (start),
    .step   (busy),
    .key_in (key_in),
    .match  (decoy_out)
  );
`else
  assign decoy_out = 1'b0;
`endif

endmodule

// File: tb/tb_sentinel_auth_ctrl.sv
// Directed self-checking bench for sentinel_auth_ctrl (UNLOCK=4, MAX_FAILS=3, LOCKOUT=8).
module tb_sentinel_auth_ctrl;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] key_in;
  logic       submit;
  logic [7:0] seg_out;
  logic       unlocked;
  logic       lockout;
  logic       busy;
  logic [3:0] fail_count;
  logic       decoy_out;

  int tests_run = 0;
  int tests_failed = 0;

  sentinel_auth_ctrl #(
    .KEY            (8'hB6),
    .UNLOCK_CYCLES  (16'd4),
    .MAX_FAILS      (3),
    .LOCKOUT_CYCLES (16'd8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .key_in     (key_in),
    .submit     (submit),
    .seg_out    (seg_out),
    .unlocked   (unlocked),
    .lockout    (lockout),
    .busy       (busy),
    .fail_count (fail_count),
    .decoy_out  (decoy_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ena = 1'b1;
    submit = 1'b0;
    key_in = 8'h00;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Raise the button for two cycles; key_in is left stable afterwards.
  task automatic press(input logic [7:0] k);
    key_in = k;
    submit = 1'b1;
    tick();
    tick();
    submit = 1'b0;
  endtask

  task automatic wait_busy(input int max, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (busy) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Counts consecutive sampled cycles for which the selected flag is high.
  task automatic count_while(input int sel, input int max, output int n);
    logic v;
    n = 0;
    for (int i = 0; i < max; i++) begin
      v = (sel == 0) ? busy : (sel == 1) ? unlocked : lockout;
      if (!v) break;
      n++;
      tick();
    end
  endtask

  // Submit a key and run through VERIFY; returns the VERIFY length or -1 on timeout.
  task automatic submit_and_verify(input logic [7:0] k, output int nbusy);
    bit seen;
    press(k);
    wait_busy(10, seen);
    if (!seen) nbusy = -1;
    else count_while(0, 30, nbusy);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ena = 1'b1;
    submit = 1'b0;
    key_in = 8'h00;
    #1;
    tests_run++;
    if (seg_out !== 8'hC7 || unlocked !== 1'b0 || lockout !== 1'b0 || busy !== 1'b0 ||
        fail_count !== 4'd0 || decoy_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: seg=%h u=%b l=%b b=%b fc=%0d d=%b, need C7 0 0 0 0 0",
               seg_out, unlocked, lockout, busy, fail_count, decoy_out);
    end
    ena = 1'b0;
    #1;
    tests_run++;
    if (seg_out !== 8'hFF) begin
      tests_failed++;
      $display("FAIL reset_ena_off_seg: got %h need FF", seg_out);
    end
    ena = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    tests_run++;
    if (seg_out !== 8'hC7 || busy !== 1'b0 || unlocked !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: seg=%h b=%b u=%b need C7 0 0", seg_out, busy, unlocked);
    end
  endtask

  task automatic test_unlock();
    int nb;
    int nu;
    do_reset();
    submit_and_verify(8'hB6, nb);
    tests_run++;
    if (nb !== 8) begin
      tests_failed++;
      $display("FAIL unlock_verify_len: got %0d need 8", nb);
    end
    tests_run++;
    if (seg_out !== 8'hC1) begin
      tests_failed++;
      $display("FAIL unlock_seg: got %h need C1", seg_out);
    end
    count_while(1, 30, nu);
    tests_run++;
    if (nu !== 4) begin
      tests_failed++;
      $display("FAIL unlock_window: got %0d need 4", nu);
    end
    tests_run++;
    if (seg_out !== 8'hC7 || fail_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL unlock_relocked: seg=%h fc=%0d need C7 0", seg_out, fail_count);
    end
  endtask

  task automatic test_wrong_keys();
    int nb;
    logic [7:0] keys [2];
    keys[0] = 8'h36;
    keys[1] = 8'hB7;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      submit_and_verify(keys[i], nb);
      tests_run++;
      if (nb !== 8 || fail_count !== 4'(i + 1) || seg_out !== 8'hC7 || unlocked !== 1'b0) begin
        tests_failed++;
        $display("FAIL wrong_key_%h: len=%0d fc=%0d seg=%h u=%b need 8 %0d C7 0",
                 keys[i], nb, fail_count, seg_out, unlocked, i + 1);
      end
    end
  endtask

  task automatic test_lockout();
    int nb;
    int nl;
    do_reset();
    submit_and_verify(8'h36, nb);
    submit_and_verify(8'hB7, nb);
    submit_and_verify(8'hFF, nb);
    tests_run++;
    if (lockout !== 1'b1 || seg_out !== 8'hBF || fail_count !== 4'd3) begin
      tests_failed++;
      $display("FAIL lockout_enter: l=%b seg=%h fc=%0d need 1 BF 3", lockout, seg_out, fail_count);
    end
    // Correct key pressed during lockout: two of the eight cycles elapse inside press().
    press(8'hB6);
    count_while(2, 30, nl);
    tests_run++;
    if (nl !== 6) begin
      tests_failed++;
      $display("FAIL lockout_len_remaining: got %0d need 6", nl);
    end
    tests_run++;
    if (fail_count !== 4'd0 || seg_out !== 8'hC7 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL lockout_exit: fc=%0d seg=%h b=%b need 0 C7 0", fail_count, seg_out, busy);
    end
    nb = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (busy || unlocked) nb++;
    end
    tests_run++;
    if (nb !== 0) begin
      tests_failed++;
      $display("FAIL lockout_submit_dropped: active cycles %0d need 0", nb);
    end
    submit_and_verify(8'hB6, nb);
    tests_run++;
    if (nb !== 8 || unlocked !== 1'b1) begin
      tests_failed++;
      $display("FAIL post_lockout_unlock: len=%0d u=%b need 8 1", nb, unlocked);
    end
  endtask

  task automatic test_relock();
    int nb;
    int nu;
    do_reset();
    submit_and_verify(8'hB6, nb);
    // Pin rises in the first UNLOCKED cycle; synchronizer delay ends the window one cycle early.
    key_in = 8'h36;
    submit = 1'b1;
    count_while(1, 30, nu);
    submit = 1'b0;
    tests_run++;
    if (nu !== 3) begin
      tests_failed++;
      $display("FAIL relock_window: got %0d need 3", nu);
    end
    nb = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy) nb++;
      tick();
    end
    tests_run++;
    if (nb !== 0 || fail_count !== 4'd0 || seg_out !== 8'hC7) begin
      tests_failed++;
      $display("FAIL relock_no_verify: busy=%0d fc=%0d seg=%h need 0 0 C7", nb, fail_count,
               seg_out);
    end
  endtask

  task automatic test_ena_abort();
    int nb;
    bit seen;
    do_reset();
    submit_and_verify(8'h36, nb);
    press(8'h36);
    wait_busy(10, seen);
    tick();
    tick();
    ena = 1'b0;
    #1;
    tests_run++;
    if (!seen || busy !== 1'b0 || seg_out !== 8'hFF) begin
      tests_failed++;
      $display("FAIL ena_off_outputs: seen=%b b=%b seg=%h need 1 0 FF", seen, busy, seg_out);
    end
    tick();
    ena = 1'b1;
    #1;
    nb = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy || unlocked) nb++;
      tick();
    end
    tests_run++;
    if (nb !== 0 || fail_count !== 4'd1 || seg_out !== 8'hC7) begin
      tests_failed++;
      $display("FAIL ena_abort: active=%0d fc=%0d seg=%h need 0 1 C7", nb, fail_count, seg_out);
    end
  endtask

  task automatic test_async_reset();
    int nb;
    do_reset();
    submit_and_verify(8'hB6, nb);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (nb !== 8 || unlocked !== 1'b0 || seg_out !== 8'hC7 || busy !== 1'b0 ||
        lockout !== 1'b0 || fail_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL async_reset: len=%0d u=%b seg=%h b=%b l=%b fc=%0d need 8 0 C7 0 0 0",
               nb, unlocked, seg_out, busy, lockout, fail_count);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_decoy();
    int nb;
    logic exp_zero_key;
`ifdef SENTINEL_DECOY_EN
    exp_zero_key = 1'b1;
`else
    exp_zero_key = 1'b0;
`endif
    do_reset();
    submit_and_verify(8'h00, nb);
    tests_run++;
    if (nb !== 8 || decoy_out !== exp_zero_key || unlocked !== 1'b0) begin
      tests_failed++;
      $display("FAIL decoy_zero_key: len=%0d d=%b u=%b need 8 %b 0", nb, decoy_out, unlocked,
               exp_zero_key);
    end
    submit_and_verify(8'hB6, nb);
    tests_run++;
    if (decoy_out !== 1'b0 || unlocked !== 1'b1) begin
      tests_failed++;
      $display("FAIL decoy_real_key: d=%b u=%b need 0 1", decoy_out, unlocked);
    end
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_wrong_keys();
    test_lockout();
    test_relock();
    test_ena_abort();
    test_async_reset();
    test_decoy();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
